// File: rtl/mem_access_unit.sv
// Load/store engine between the CPU datapath and a word-addressed data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam logic [31:0] LP_DEPTH = MEM_DEPTH;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rbuf;
  logic        r_err;

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_req_err;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // Request classification is done on the live inputs so the error path can skip RD/WR.
  always_comb begin
    w_illegal      = req_write ? (req_funct3 > 3'd2)
                               : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
    w_misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    w_out_of_range = {2'b00, req_addr[31:2]} >= LP_DEPTH;
    w_req_err      = w_illegal || w_misaligned || w_out_of_range;
    w_accept       = (r_state == S_IDLE) && req_valid;
  end

  // NOTE: reset here is synchronous, so it lives inside the clocked branch rather than the
  // sensitivity list; all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rbuf   <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == S_RD) r_rbuf <= mem_dout;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err)                 w_next = S_RESP;
          else if (!req_write)           w_next = S_RD;
          else if (req_funct3 == 3'd2)   w_next = S_WR;
          else                           w_next = S_RD;
        end
      end
      S_RD:    w_next = r_write ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = r_rbuf[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_rbuf[{r_addr[1], 4'b0000} +: 16];
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd4:    w_load_data = {24'd0, w_byte};
      3'd5:    w_load_data = {16'd0, w_half};
      default: w_load_data = r_rbuf;
    endcase

    w_merged = r_rbuf;
    case (r_funct3[1:0])
      2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  // Outputs are forced quiet during reset so an aborted access can never commit.
  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_din    = 32'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    if (!reset) begin
      case (r_state)
        S_IDLE: req_ready = 1'b1;
        S_RD: begin
          mem_read = 1'b1;
          mem_addr = {r_addr[31:2], 2'b00};
        end
        S_WR: begin
          mem_write = 1'b1;
          mem_addr  = {r_addr[31:2], 2'b00};
          mem_din   = w_merged;
        end
        S_RESP: begin
          resp_valid = 1'b1;
          resp_err   = r_err;
          if (!r_write && !r_err) resp_rdata = w_load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized loads/stores
// compared against a byte-lane arithmetic model of memory and responses.
module tb_mem_access_unit;

  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  assign mem_dout = tb_mem[mem_addr[15:2]];

  always @(posedge clk)
    if (mem_write && mem_addr[31:16] == 16'd0) tb_mem[mem_addr[15:2]] <= mem_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One request through the handshake; expectations come from the byte-lane model below.
  task automatic run_op(input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          size, sh, idx, exp_lat, lat, reads, writes;
    logic        illegal, misal, oor, err;
    logic [31:0] mask, word, raw, new_word, exp_rdata;

    size    = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    illegal = wr ? (f3 > 2) : (f3 == 3 || f3 > 5);
    misal   = (addr % size) != 0;
    oor     = (addr / 4) >= DEPTH;
    err     = illegal || misal || oor;
    idx     = oor ? 0 : int'(addr / 4);
    mask    = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh      = (size == 4) ? 0 : int'(addr % 4) * 8;
    word    = ref_mem[idx];

    raw = (word >> sh) & mask;
    if (f3 < 2 && (raw & ((mask >> 1) + 32'd1)) != 0) raw = raw | ~mask;
    exp_rdata = (err || wr) ? 32'd0 : raw;
    new_word  = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    exp_lat   = err ? 1 : (!wr || size == 4) ? 2 : 3;
    if (wr && !err) ref_mem[idx] = new_word;

    check("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;

    lat = 0; reads = 0; writes = 0;
    for (int k = 1; k <= 6; k++) begin
      if (mem_read) begin
        reads++;
        check("rd_addr", mem_addr, addr & 32'hFFFF_FFFC);
      end
      if (mem_write) begin
        writes++;
        check("wr_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("wr_din", mem_din, new_word);
      end
      if (resp_valid) begin
        lat = k;
        check("resp_err", {31'd0, resp_err}, {31'd0, err});
        check("resp_rdata", resp_rdata, exp_rdata);
        break;
      end
      @(negedge clk);
    end
    check("latency", lat, exp_lat);
    check("read_cycles", reads, (!err && (!wr || size < 4)) ? 1 : 0);
    check("write_cycles", writes, (!err && wr) ? 1 : 0);
    if (!oor) check("mem_word", tb_mem[idx], ref_mem[idx]);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Store then load back a full word.
    run_op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);

    // Reset held with a pending store request: nothing may reach memory.
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    req_wdata  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsthold_ready", {31'd0, req_ready}, 32'd0);
      check("rsthold_mem_write", {31'd0, mem_write}, 32'd0);
    end
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("rsthold_mem", tb_mem[4], ref_mem[4]);

    run_op(1'b0, 3'd2, 32'h10, 32'h0);
    run_op(1'b1, 3'd0, 32'h12, 32'h55);

    // Load extension on 0x80FF7F01.
    run_op(1'b1, 3'd2, 32'h10, 32'h80FF_7F01);
    run_op(1'b0, 3'd0, 32'h11, 32'h0);
    run_op(1'b0, 3'd0, 32'h12, 32'h0);
    run_op(1'b0, 3'd4, 32'h12, 32'h0);
    run_op(1'b0, 3'd1, 32'h12, 32'h0);
    run_op(1'b0, 3'd5, 32'h12, 32'h0);

    // Error cases.
    run_op(1'b0, 3'd2, 32'h13, 32'h0);
    run_op(1'b1, 3'd1, 32'h11, 32'hFFFF);
    run_op(1'b0, 3'd3, 32'h10, 32'h0);
    run_op(1'b0, 3'd2, 32'h10000, 32'h0);
    run_op(1'b1, 3'd4, 32'h10, 32'h1);

    // Reset during the WR cycle of a byte store aborts the write.
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h12;
    req_wdata  = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_rd", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    check("abort_wr_pre", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_wr_forced", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    check("abort_mem", tb_mem[4], ref_mem[4]);
    @(negedge clk);
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);

    // Randomized traffic over a small window, seeded by known full-word stores.
    for (int w = 4; w < 12; w++) run_op(1'b1, 3'd2, 32'(w * 4), $urandom);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'h10 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = 32'h10000 + 32'($urandom_range(0, 255));
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
